// File: rtl/ff_bank_pkg.sv
// Shared types, mode encodings and the per-bit next-state rule for the ff_bank slice.
// Every bit of the bank and the bank-level change detector use the same rule.
package ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK = 2'b00;
    localparam mode_t MODE_SR = 2'b01;
    localparam mode_t MODE_D  = 2'b10;
    localparam mode_t MODE_T  = 2'b11;

    // SR treats the forbidden S=R=1 input as a hold; flagging it is the bank's job.
    function automatic logic ff_next(
        input mode_t mode,
        input logic  q,
        input logic  j,
        input logic  k
    );
        logic nxt;
        nxt = q;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b00:   nxt = q;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = ~q;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = q;
                endcase
            end
            MODE_D:  nxt = j;
            default: nxt = q ^ j;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ff_bit.sv
// Single mode-selectable flip-flop: JK, SR, D or T chosen per cycle by i_mode.
// Holds its state whenever i_en is low, so unknown j/k values cannot leak into q.
module ff_bit
    import ff_bank_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_en,
    input  mode_t i_mode,
    input  logic  i_j,
    input  logic  i_k,
    input  logic  i_rst_val,
    output logic  o_q
);

    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= i_rst_val;
        end else if (i_en) begin
            r_q <= ff_next(i_mode, r_q, i_j, i_k);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with a saturating change counter
// and a sticky flag for forbidden SR inputs.
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic [CNT_W-1:0] o_chg_cnt,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_chg;
    logic             w_sr_viol;
    logic [CNT_W-1:0] r_chg_cnt;
    logic             r_err;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        ff_bit u_ff_bit (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .i_mode    (i_mode),
            .i_j       (i_j[g]),
            .i_k       (i_k[g]),
            .i_rst_val (RST_VAL[g]),
            .o_q       (w_q[g])
        );
    end

    // Predict the value each bit is about to load so the counter moves on the same edge as q.
    always_comb begin
        w_q_next = w_q;
        for (int i = 0; i < WIDTH; i++) begin
            w_q_next[i] = ff_next(i_mode, w_q[i], i_j[i], i_k[i]);
        end
    end

    assign w_chg     = i_en && (w_q_next != w_q);
    assign w_sr_viol = i_en && (i_mode == MODE_SR) && (|(i_j & i_k));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chg_cnt <= '0;
        end else if (w_chg && (r_chg_cnt != CNT_MAX)) begin
            r_chg_cnt <= r_chg_cnt + 1'b1;
        end
    end

    // A fresh violation beats a simultaneous clear; the clear works even with i_en low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_sr_viol) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_q       = w_q;
    assign o_qbar    = ~w_q;
    assign o_chg_cnt = r_chg_cnt;
    assign o_err     = r_err;

endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank: reset, JK/SR/D/T behaviour, hold,
// sticky error handling, mid-cycle reset and counter saturation (second instance, CNT_W=4).
module tb_ff_bank;
    import ff_bank_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    mode_t       mode;
    logic [7:0]  j;
    logic [7:0]  k;
    logic        err_clr;

    logic [7:0]  q;
    logic [7:0]  qbar;
    logic [15:0] chg_cnt;
    logic        err;

    logic [7:0]  s_q;
    logic [7:0]  s_qbar;
    logic [3:0]  s_chg_cnt;
    logic        s_err;

    int n_checks = 0;
    int n_errors = 0;

    ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(16)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_mode    (mode),
        .i_j       (j),
        .i_k       (k),
        .i_err_clr (err_clr),
        .o_q       (q),
        .o_qbar    (qbar),
        .o_chg_cnt (chg_cnt),
        .o_err     (err)
    );

    ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut_sat (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_mode    (mode),
        .i_j       (j),
        .i_k       (k),
        .i_err_clr (err_clr),
        .o_q       (s_q),
        .o_qbar    (s_qbar),
        .o_chg_cnt (s_chg_cnt),
        .o_err     (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic [15:0] ecnt,
                             input logic eerr);
        chk({tag, ".q"}, {24'h0, q}, {24'h0, eq});
        chk({tag, ".qbar"}, {24'h0, qbar}, {24'h0, ~eq});
        chk({tag, ".cnt"}, {16'h0, chg_cnt}, {16'h0, ecnt});
        chk({tag, ".err"}, {31'h0, err}, {31'h0, eerr});
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = MODE_D; j = 8'h00; k = 8'h00; err_clr = 1'b0;

        // Asynchronous reset asserted between edges
        #2 rst = 1'b1;
        #1 chk_state("rst_async", 8'hA5, 16'd0, 1'b0);

        // Inputs ignored while in reset
        en = 1'b1; mode = MODE_D; j = 8'hFF;
        tick();
        chk_state("rst_hold", 8'hA5, 16'd0, 1'b0);

        // First edge after release updates: D load of 00 from A5 counts one change
        rst = 1'b0; j = 8'h00;
        tick();
        chk_state("d_clear", 8'h00, 16'd1, 1'b0);

        // JK sequence on bit 0, three changes on top of the one above
        mode = MODE_JK; j = 8'h00; k = 8'h00;
        tick(); chk_state("jk_00", 8'h00, 16'd1, 1'b0);
        j = 8'h00; k = 8'h01;
        tick(); chk_state("jk_01", 8'h00, 16'd1, 1'b0);
        j = 8'h01; k = 8'h00;
        tick(); chk_state("jk_10", 8'h01, 16'd2, 1'b0);
        j = 8'h01; k = 8'h01;
        tick(); chk_state("jk_11a", 8'h00, 16'd3, 1'b0);
        tick(); chk_state("jk_11b", 8'h01, 16'd4, 1'b0);

        // SR forbidden input holds the bit and sets the sticky flag
        mode = MODE_SR; j = 8'h01; k = 8'h01;
        tick(); chk_state("sr_illegal", 8'h01, 16'd4, 1'b1);
        j = 8'h00; k = 8'h00;
        tick(); chk_state("sr_sticky", 8'h01, 16'd4, 1'b1);
        err_clr = 1'b1;
        tick(); chk_state("sr_clr", 8'h01, 16'd4, 1'b0);
        j = 8'h01; k = 8'h01;
        tick(); chk_state("sr_set_wins", 8'h01, 16'd4, 1'b1);
        err_clr = 1'b0; j = 8'h00; k = 8'h00; en = 1'b0;
        err_clr = 1'b1;
        tick(); chk_state("clr_en0", 8'h01, 16'd4, 1'b0);
        err_clr = 1'b0; en = 1'b1;

        // D then T
        mode = MODE_D; j = 8'h3C;
        tick(); chk_state("d_3c", 8'h3C, 16'd5, 1'b0);
        mode = MODE_T; j = 8'hFF;
        tick(); chk_state("t_ff", 8'hC3, 16'd6, 1'b0);

        // Hold with en=0 across modes, including SR with forbidden input
        en = 1'b0; j = 8'hFF; k = 8'hFF;
        mode = MODE_SR; tick(); chk_state("hold_sr", 8'hC3, 16'd6, 1'b0);
        mode = MODE_JK; tick(); chk_state("hold_jk", 8'hC3, 16'd6, 1'b0);
        mode = MODE_T;  tick(); chk_state("hold_t", 8'hC3, 16'd6, 1'b0);

        // Reset mid-cycle discards a pending D load of 0F
        en = 1'b1; mode = MODE_D; j = 8'h0F; k = 8'h00;
        #2 rst = 1'b1;
        #1 chk_state("rst_mid", 8'hA5, 16'd0, 1'b0);
        tick(); chk_state("rst_mid_edge", 8'hA5, 16'd0, 1'b0);
        rst = 1'b0; en = 1'b0;
        tick(); chk_state("post_rst_en0", 8'hA5, 16'd0, 1'b0);
        en = 1'b1; j = 8'h5A;
        tick(); chk_state("post_rst_d", 8'h5A, 16'd1, 1'b0);

        // Saturation: toggle bit 0 for 20 edges; CNT_W=4 instance caps at 15
        rst = 1'b1;
        #1 rst = 1'b0;
        chk("sat_rst.cnt", {28'h0, s_chg_cnt}, 32'd0);
        mode = MODE_T; j = 8'h01; k = 8'h00; en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) chk("sat_14", {28'h0, s_chg_cnt}, 32'd14);
            if (n == 15) begin
                chk("sat_15", {28'h0, s_chg_cnt}, 32'd15);
                chk("sat_15.q", {24'h0, s_q}, 32'h0000_00A4);
            end
            if (n == 16) chk("sat_16", {28'h0, s_chg_cnt}, 32'd15);
        end
        chk("sat_20", {28'h0, s_chg_cnt}, 32'd15);
        chk("sat_20.q", {24'h0, s_q}, 32'h0000_00A5);
        chk("sat_20.qbar", {24'h0, s_qbar}, 32'h0000_005A);
        chk_state("wide_cnt_20", 8'hA5, 16'd20, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ff_bank.md
FF_BANK -- requirements
Module: ff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank (1..32).
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Parameter CNT_W, default 16, width of the change counter.
REQ-004 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  update enable; 0 holds all state except the err_clr path.
REQ-007 Port mode  input  2  per-cycle flip-flop behaviour: 00 JK, 01 SR, 10 D, 11 T.
REQ-008 Port j  input  WIDTH  J / S / D / T input per bit, depending on mode.
REQ-009 Port k  input  WIDTH  K / R input per bit; ignored in D and T modes.
REQ-010 Port err_clr  input  1  synchronous clear of the sticky error flag.
REQ-011 Port q  output  WIDTH  registered state.
REQ-012 Port qbar  output  WIDTH  bitwise complement of q at all times.
REQ-013 Port chg_cnt  output  CNT_W  saturating count of clock edges on which q changed.
REQ-014 Port err  output  1  sticky flag: illegal SR input seen.

Function
REQ-015 When en=0, q, chg_cnt and err shall hold; the err_clr path in REQ-022 still applies.
REQ-016 With en=1, the next value of bit i shall be:
- JK: j=0,k=0 hold; j=0,k=1 0; j=1,k=0 1; j=1,k=1 toggle.
- SR: same mapping as JK, except j=1,k=1 holds the bit.
- D: j[i].
- T: q[i]^j[i].
REQ-017 mode, j, k and en shall be sampled on the same rising edge; q shall update with one-cycle latency and no combinational path from inputs to q.
REQ-018 qbar shall equal ~q combinationally and shall never show a q/qbar equal pair.
REQ-019 chg_cnt shall increment by 1 on each edge where the new q differs from the old q in any bit, and shall saturate at 2^CNT_W-1 with no wrap.
REQ-020 err shall set on an edge where en=1, mode=SR and (j&k)!=0.
REQ-021 err_clr=1 shall clear err on the next edge.
REQ-022 If err_clr=1 and a new SR violation occur on the same edge, the set shall win and err shall be 1.
REQ-023 A change of mode between cycles shall take effect immediately and shall not disturb the stored q.
REQ-024 X on j or k while en=0 shall not propagate to q.

Reset
REQ-025 Asserting rst shall immediately force q=RST_VAL, qbar=~RST_VAL, chg_cnt=0 and err=0, regardless of clk.
REQ-026 While rst=1, all inputs shall be ignored.
REQ-027 After rst deasserts, the first update shall occur on the first rising edge with rst=0 and en=1.
REQ-028 Reset asserted mid-sequence shall discard any pending update from that cycle.

Structure
REQ-029 Package ff_bank_pkg shall hold:
- the 2-bit mode type;
- constants MODE_JK=2'b00, MODE_SR=2'b01, MODE_D=2'b10, MODE_T=2'b11;
- the next-state function used by all bits.
REQ-030 One sub-module ff_bit shall implement a single-bit, mode-selectable flip-flop (clk, rst, en, mode, j, k, rst_val, q), instantiated WIDTH times via generate.
REQ-031 chg_cnt, err and the change-detect compare shall live in ff_bank, not in ff_bit.

Verification
REQ-032 Reset: WIDTH=8, RST_VAL=8'hA5, rst=1 mid-cycle -> q=A5 and qbar=5A immediately; chg_cnt=0; err=0.
REQ-033 JK sequence on bit 0 from q=0, en=1:
- (j,k)=00 -> 0
- 01 -> 0
- 10 -> 1
- 11 -> 0
- 11 -> 1
- chg_cnt=3.
REQ-034 SR illegal: mode=01, j=k=8'h01, q[0]=1 -> q[0] stays 1 and err=1; err_clr=1 with no violation -> err=0 next edge; err_clr=1 concurrent with a violation -> err=1.
REQ-035 D/T/hold:
- mode=10, j=8'h3C -> q=3C.
- mode=11, j=8'hFF -> q=C3.
- en=0 with j=k=8'hFF, any mode, 3 edges -> q=C3 and chg_cnt unchanged.
REQ-036 Saturation: CNT_W=4, mode=T, j=8'h01, en=1 for 20 edges -> chg_cnt reaches 15 and stays at 15.
